regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port among NUM_REQ writeback requesters: ALU, load unit and CSR/mul unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered output stage drives the register file write port.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds data/address widths, register count, output reset value and the
// index-width helper used to size grant ids.
package regfile_wb_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_NUM    = 32;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] regAddr_t;

    localparam data_t DATA_RST = '0;

    // Bits needed to encode an index in [0, n-1]; never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: per-requester valid/addr/data and one-hot ready.
// master: requester side (drives valid/addr/data); slave: arbiter side.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int ADDR_W  = ADDR_WIDTH
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared port.
// Ports: req (request vector), rrPtr (last winner), en -> gnt (one-hot), gntIdx.
module regfile_wb_arbiter_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rrPtr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gntIdx
);

    // Scan rrPtr+1, rrPtr+2, ... wrapping, and take the first requester.
    always_comb begin
        int  idx;
        logic found;
        gnt    = '0;
        gntIdx = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gntIdx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback requesters.
// Ports: clk, rst (sync, active-low), req (request bundle, slave),
//   wb_stall, we_o/wr_addr_o/wr_data_o (registered write port), grant_id_o.
// `define WB_FORWARD_EN adds rd_addr_a/b, rf_rd_a/b in and fwd_rd_a/b out.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int ADDR_W  = ADDR_WIDTH,
    localparam int GID_W  = clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_arbiter_if.slave req,
    input  logic              wb_stall,
    output logic              we_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [GID_W-1:0]  grant_id_o
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_a,
    input  logic [DATA_W-1:0] rf_rd_b,
    output logic [DATA_W-1:0] fwd_rd_a,
    output logic [DATA_W-1:0] fwd_rd_b
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic [GID_W-1:0]   gntIdx;
    logic [GID_W-1:0]   rrPtr;
    logic               grantEn;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selData;

    assign grantEn = rst & ~wb_stall;

    regfile_wb_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uArb (
        .req    (req.req_valid),
        .rrPtr  (rrPtr),
        .en     (grantEn),
        .gnt    (gnt),
        .gntIdx (gntIdx)
    );

    assign req.req_ready = gnt;
    assign selAddr = req.req_addr[int'(gntIdx)*ADDR_W +: ADDR_W];
    assign selData = req.req_data[int'(gntIdx)*DATA_W +: DATA_W];

    // A stall freezes everything, so the pending write is re-presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_o       <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= DATA_W'(DATA_RST);
            grant_id_o <= '0;
            rrPtr      <= GID_W'(NUM_REQ - 1);
        end else if (!wb_stall) begin
            if (|gnt) begin
                we_o       <= (selAddr != '0);
                wr_addr_o  <= selAddr;
                wr_data_o  <= selData;
                grant_id_o <= gntIdx;
                rrPtr      <= gntIdx;
            end else begin
                we_o <= 1'b0;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // we_o is never set for x0, so address 0 can never forward.
    assign fwd_rd_a = (we_o && rd_addr_a != '0 && wr_addr_o == rd_addr_a)
                    ? wr_data_o : rf_rd_a;
    assign fwd_rd_b = (we_o && rd_addr_b != '0 && wr_addr_o == rd_addr_b)
                    ? wr_data_o : rf_rd_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of grants and the write port.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_stall = 1'b0;
    logic          we_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [1:0]    grant_id_o;
`ifdef WB_FORWARD_EN
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] rf_rd_a = '0;
    logic [DW-1:0] rf_rd_b = '0;
    logic [DW-1:0] fwd_rd_a;
    logic [DW-1:0] fwd_rd_b;
`endif

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) rbus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (rbus),
        .wb_stall   (wb_stall),
        .we_o       (we_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .grant_id_o (grant_id_o)
`ifdef WB_FORWARD_EN
        ,
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rf_rd_a    (rf_rd_a),
        .rf_rd_b    (rf_rd_b),
        .fwd_rd_a   (fwd_rd_a),
        .fwd_rd_b   (fwd_rd_b)
`endif
    );

    always #5 clk = ~clk;

    // Requester rule: a valid that was not accepted stays, with stable payload.
    logic [N-1:0]    pV = '0;
    logic [N-1:0]    pR = '0;
    logic [N*AW-1:0] pA = '0;
    logic [N*DW-1:0] pD = '0;
    logic            pRst = 1'b0;

    always @(posedge clk) begin
        if (pRst && rst) begin
            for (int i = 0; i < N; i++) begin
                if (pV[i] && !pR[i]) begin
                    assert (rbus.req_valid[i]
                            && rbus.req_addr[i*AW +: AW] == pA[i*AW +: AW]
                            && rbus.req_data[i*DW +: DW] == pD[i*DW +: DW])
                    else $error("requester %0d broke hold rule", i);
                end
            end
        end
        pRst <= rst;
        pV   <= rbus.req_valid;
        pR   <= rbus.req_ready;
        pA   <= rbus.req_addr;
        pD   <= rbus.req_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        rbus.req_valid[i]          = v;
        rbus.req_addr[i*AW +: AW]  = a;
        rbus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic doReset();
        rst = 1'b0;
        wb_stall = 1'b0;
        rbus.req_valid = '0;
        rbus.req_addr = '0;
        rbus.req_data = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Expected winner: the valid requester closest after the last winner.
    function automatic int expGrant(input logic [N-1:0] v, input int last,
                                    input logic st);
        int best;
        int bestD;
        int d;
        best = -1;
        bestD = N;
        if (st) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + N) % N;
                if (d < bestD) begin
                    bestD = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        wb_stall = 1'b0;
        setReq(0, 1'b1, 5'd1, 32'hA);
        setReq(1, 1'b1, 5'd2, 32'hB);
        setReq(2, 1'b1, 5'd3, 32'hC);
        cyc();
        cyc();
        tests++;
        if (rbus.req_ready !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 000", rbus.req_ready);
        end
        tests++;
        if ({we_o, wr_addr_o, wr_data_o, grant_id_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h gid=%0d want all 0",
                     we_o, wr_addr_o, wr_data_o, grant_id_o);
        end
        rbus.req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        doReset();
        setReq(0, 1'b1, 5'd1, 32'hA);
        setReq(1, 1'b1, 5'd2, 32'hB);
        setReq(2, 1'b1, 5'd3, 32'hC);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (rbus.req_ready !== 3'(1 << (i % 3))) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b want %b", i,
                         rbus.req_ready, 3'(1 << (i % 3)));
            end
            cyc();
            tests++;
            if (we_o !== 1'b1 || wr_addr_o !== 5'(i % 3 + 1)
                || wr_data_o !== 32'(32'hA + i % 3)
                || grant_id_o !== 2'(i % 3)) begin
                fails++;
                $display("FAIL rr_write%0d: we=%b addr=%0d data=%h gid=%0d want 1/%0d/%h/%0d",
                         i, we_o, wr_addr_o, wr_data_o, grant_id_o,
                         i % 3 + 1, 32'hA + i % 3, i % 3);
            end
        end
        rbus.req_valid = '0;
    endtask

    task automatic test_x0_write();
        doReset();
        setReq(1, 1'b1, 5'd0, 32'hDEAD);
        #1;
        tests++;
        if (rbus.req_ready !== 3'b010) begin
            fails++;
            $display("FAIL x0_ready: got %b want 010", rbus.req_ready);
        end
        cyc();
        rbus.req_valid = '0;
        tests++;
        if (we_o !== 1'b0 || wr_addr_o !== 5'd0 || grant_id_o !== 2'd1
            || wr_data_o !== 32'hDEAD) begin
            fails++;
            $display("FAIL x0_write: we=%b addr=%0d gid=%0d data=%h want 0/0/1/dead",
                     we_o, wr_addr_o, grant_id_o, wr_data_o);
        end
    endtask

    task automatic test_stall();
        doReset();
        setReq(2, 1'b1, 5'd7, 32'h55);
        #1;
        tests++;
        if (rbus.req_ready !== 3'b100) begin
            fails++;
            $display("FAIL stall_pre_ready: got %b want 100", rbus.req_ready);
        end
        cyc();
        setReq(0, 1'b1, 5'd11, 32'h111);
        setReq(1, 1'b1, 5'd12, 32'h222);
        setReq(2, 1'b1, 5'd13, 32'h333);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (rbus.req_ready !== 3'b000 || we_o !== 1'b1
                || wr_addr_o !== 5'd7 || wr_data_o !== 32'h55) begin
                fails++;
                $display("FAIL stall_hold%0d: rdy=%b we=%b addr=%0d data=%h want 000/1/7/55",
                         i, rbus.req_ready, we_o, wr_addr_o, wr_data_o);
            end
            cyc();
        end
        tests++;
        if (we_o !== 1'b1 || wr_addr_o !== 5'd7 || wr_data_o !== 32'h55) begin
            fails++;
            $display("FAIL stall_end: we=%b addr=%0d data=%h want 1/7/55",
                     we_o, wr_addr_o, wr_data_o);
        end
        wb_stall = 1'b0;
        #1;
        tests++;
        if (rbus.req_ready !== 3'b001) begin
            fails++;
            $display("FAIL stall_release_ready: got %b want 001", rbus.req_ready);
        end
        cyc();
        rbus.req_valid = '0;
        tests++;
        if (we_o !== 1'b1 || wr_addr_o !== 5'd11 || wr_data_o !== 32'h111) begin
            fails++;
            $display("FAIL stall_release_write: we=%b addr=%0d data=%h want 1/11/111",
                     we_o, wr_addr_o, wr_data_o);
        end
    endtask

    task automatic test_reset_midop();
        doReset();
        setReq(0, 1'b1, 5'd4, 32'h99);
        cyc();
        tests++;
        if (we_o !== 1'b1 || wr_addr_o !== 5'd4 || wr_data_o !== 32'h99) begin
            fails++;
            $display("FAIL midrst_pre: we=%b addr=%0d data=%h want 1/4/99",
                     we_o, wr_addr_o, wr_data_o);
        end
        rst = 1'b0;
        setReq(0, 1'b1, 5'd9, 32'h909);
        setReq(1, 1'b1, 5'd10, 32'hA0A);
        setReq(2, 1'b1, 5'd14, 32'hE0E);
        #1;
        tests++;
        if (rbus.req_ready !== 3'b000) begin
            fails++;
            $display("FAIL midrst_ready: got %b want 000", rbus.req_ready);
        end
        cyc();
        tests++;
        if ({we_o, wr_addr_o, wr_data_o, grant_id_o} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: we=%b addr=%0d data=%h gid=%0d want all 0",
                     we_o, wr_addr_o, wr_data_o, grant_id_o);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rbus.req_ready !== 3'b001) begin
            fails++;
            $display("FAIL midrst_ptr: got %b want 001", rbus.req_ready);
        end
        cyc();
        rbus.req_valid = '0;
        tests++;
        if (we_o !== 1'b1 || wr_addr_o !== 5'd9 || wr_data_o !== 32'h909) begin
            fails++;
            $display("FAIL midrst_after: we=%b addr=%0d data=%h want 1/9/909",
                     we_o, wr_addr_o, wr_data_o);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0]  va;
        logic [AW-1:0] aa [N];
        logic [DW-1:0] da [N];
        logic [N-1:0]  done;
        logic [N-1:0]  rdy;
        logic          st;
        int            last;
        int            g;
        int            got;
        int            waits [N];
        logic          mWe;
        logic [AW-1:0] mAddr;
        logic [DW-1:0] mData;
        logic [1:0]    mGid;
        doReset();
        va = '0;
        done = '0;
        last = N - 1;
        mWe = 1'b0;
        mAddr = '0;
        mData = '0;
        mGid = '0;
        for (int i = 0; i < N; i++) begin
            waits[i] = 0;
            aa[i] = '0;
            da[i] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i] || done[i]) begin
                    va[i] = 1'($urandom_range(0, 1));
                    aa[i] = AW'($urandom_range(0, 31));
                    da[i] = $urandom;
                end
                setReq(i, va[i], aa[i], da[i]);
            end
            st = ($urandom_range(0, 9) == 0);
            wb_stall = st;
            #1;
            g = expGrant(va, last, st);
            rdy = rbus.req_ready;
            tests++;
            if (rdy !== ((g < 0) ? 3'b000 : 3'(1 << g))) begin
                fails++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, rdy,
                         (g < 0) ? 3'b000 : 3'(1 << g));
            end
            got = -1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] && va[i]) got = i;
            end
            done = rdy & va;
            if (got >= 0) begin
                tests++;
                if (waits[got] > N - 1) begin
                    fails++;
                    $display("FAIL rand_fair c%0d: req%0d waited %0d grants, limit %0d",
                             c, got, waits[got], N - 1);
                end
                for (int i = 0; i < N; i++) begin
                    if (i == got) waits[i] = 0;
                    else if (va[i]) waits[i]++;
                end
            end
            cyc();
            if (g >= 0) begin
                mWe = (aa[g] != '0);
                mAddr = aa[g];
                mData = da[g];
                mGid = 2'(g);
                last = g;
            end else if (!st) begin
                mWe = 1'b0;
            end
            tests++;
            if ({we_o, wr_addr_o, wr_data_o, grant_id_o}
                !== {mWe, mAddr, mData, mGid}) begin
                fails++;
                $display("FAIL rand_write c%0d: got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                         c, we_o, wr_addr_o, wr_data_o, grant_id_o,
                         mWe, mAddr, mData, mGid);
            end
        end
        wb_stall = 1'b0;
        doReset();
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        doReset();
        setReq(0, 1'b1, 5'd5, 32'h1234);
        cyc();
        rbus.req_valid = '0;
        wb_stall = 1'b1;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd6;
        rf_rd_a = 32'hAAAA;
        rf_rd_b = 32'h77;
        #1;
        tests++;
        if (fwd_rd_a !== 32'h1234 || fwd_rd_b !== 32'h77) begin
            fails++;
            $display("FAIL fwd_hit: a=%h b=%h want 1234/77", fwd_rd_a, fwd_rd_b);
        end
        wb_stall = 1'b0;
        setReq(1, 1'b1, 5'd0, 32'h4321);
        cyc();
        rbus.req_valid = '0;
        wb_stall = 1'b1;
        rd_addr_a = 5'd0;
        #1;
        tests++;
        if (fwd_rd_a !== 32'hAAAA) begin
            fails++;
            $display("FAIL fwd_x0: a=%h want aaaa", fwd_rd_a);
        end
        wb_stall = 1'b0;
    endtask
`endif

    initial begin
        rbus.req_valid = '0;
        rbus.req_addr = '0;
        rbus.req_data = '0;
        test_reset();
        test_round_robin();
        test_x0_write();
        test_stall();
        test_reset_midop();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_fairness();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
